i2c_slave_rx: RTL and testbench

I2C slave receiver on the bench memory path: filters SCL/SDA, detects START/STOP, matches a 7-bit slave address, ACKs, and delivers every received byte to the downstream I2C-to-Wishbone memory writer. Output is a byte bus plus a one-cycle byte-valid strobe and a stop strobe. The first byte of a transaction is the address byte, with R/W in bit 0. Only master-write transfers carry data; reads are ACKed at address and then ignored.

---
 rtl/i2c_pkg.sv | 18 +
 rtl/i2c_glitch_filter.sv | 45 ++++
 rtl/i2c_slave_rx.sv | 145 ++++++++++++++
 tb/tb_i2c_slave_rx.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave receive path.
package i2c_pkg;

   localparam int unsigned I2C_ADDR_W = 7;
   localparam int unsigned I2C_RW_BIT = 0;
   localparam int unsigned I2C_BYTE_W = 8;
   localparam int unsigned I2C_CNT_W  = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_DATA,
      ST_DATA_ACK,
      ST_IGNORE
   } i2c_rx_state_t;

endpackage

// File: rtl/i2c_glitch_filter.sv
// 2-FF synchronizer plus stability filter: the output follows the
// synchronized line only after it has differed for FILTER_LEN cycles.
module i2c_glitch_filter #(
   parameter int unsigned FILTER_LEN = 3
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic raw,
   output logic filt
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic [CNT_W-1:0] cnt_q;

   // Two-stage synchronizer, idles high like the bus
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
      end
   end

   // Accept a new level once it has been seen FILTER_LEN cycles in a row
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
         filt  <= 1'b1;
      end else if (sync2_q == filt) begin
         cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_q <= '0;
         filt  <= sync2_q;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/i2c_slave_rx.sv
// I2C slave receiver: filters the bus, tracks START/STOP, matches the
// slave address, ACKs, and hands every accepted byte downstream.
module i2c_slave_rx
   import i2c_pkg::*;
#(
   parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h50,
   parameter int unsigned           FILTER_LEN = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  scl_i,
   input  logic                  sda_i,
   output logic                  sda_oe_o,
   output logic [I2C_BYTE_W-1:0] dat_o,
   output logic                  dat_avail_o,
   output logic                  stop_o,
   output logic                  busy_o
);

   localparam logic [I2C_CNT_W-1:0] LAST_BIT = '1;

   logic                  scl_f;
   logic                  sda_f;
   logic                  scl_d;
   logic                  sda_d;
   i2c_rx_state_t         state_q;
   logic [I2C_CNT_W-1:0]  bit_cnt_q;
   logic [I2C_BYTE_W-1:0] shift_q;

   logic                  scl_rise_c;
   logic                  scl_fall_c;
   logic                  start_c;
   logic                  stop_c;
   logic [I2C_BYTE_W-1:0] byte_c;

   i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .raw     (scl_i),
      .filt    (scl_f)
   );

   i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .raw     (sda_i),
      .filt    (sda_f)
   );

   // One-cycle delayed copies of the filtered lines for edge detection
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         scl_d <= 1'b1;
         sda_d <= 1'b1;
      end else begin
         scl_d <= scl_f;
         sda_d <= sda_f;
      end
   end

   // Bus events; START/STOP are masked while we hold SDA ourselves
   always_comb begin
      scl_rise_c = scl_f & ~scl_d;
      scl_fall_c = ~scl_f & scl_d;
      start_c    = sda_d & ~sda_f & scl_f & ~sda_oe_o;
      stop_c     = ~sda_d & sda_f & scl_f & ~sda_oe_o;
      byte_c     = {shift_q[I2C_BYTE_W-2:0], sda_f};
   end

   // Receive FSM with shift register, byte strobe and ACK drive
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         dat_o       <= '0;
         dat_avail_o <= 1'b0;
         stop_o      <= 1'b0;
         busy_o      <= 1'b0;
         sda_oe_o    <= 1'b0;
      end else begin
         dat_avail_o <= 1'b0;
         stop_o      <= 1'b0;
         if (stop_c) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            sda_oe_o  <= 1'b0;
            busy_o    <= 1'b0;
            stop_o    <= busy_o;
         end else if (start_c) begin
            state_q   <= ST_ADDR;
            bit_cnt_q <= '0;
            shift_q   <= '0;
         end else begin
            case (state_q)
               ST_ADDR: begin
                  if (scl_rise_c) begin
                     shift_q   <= byte_c;
                     bit_cnt_q <= bit_cnt_q + I2C_CNT_W'(1);
                     if (bit_cnt_q == LAST_BIT) begin
                        if (byte_c[I2C_BYTE_W-1:1] == SLAVE_ADDR) begin
                           dat_o       <= byte_c;
                           dat_avail_o <= 1'b1;
                           busy_o      <= 1'b1;
                           state_q     <= ST_ADDR_ACK;
                        end else begin
                           busy_o  <= 1'b0;
                           state_q <= ST_IGNORE;
                        end
                     end
                  end
               end
               ST_DATA: begin
                  if (scl_rise_c) begin
                     shift_q   <= byte_c;
                     bit_cnt_q <= bit_cnt_q + I2C_CNT_W'(1);
                     if (bit_cnt_q == LAST_BIT) begin
                        dat_o       <= byte_c;
                        dat_avail_o <= 1'b1;
                        state_q     <= ST_DATA_ACK;
                     end
                  end
               end
               ST_ADDR_ACK, ST_DATA_ACK: begin
                  // First fall ends bit 8 and starts the ACK, second ends the 9th clock
                  if (scl_fall_c) begin
                     if (!sda_oe_o) begin
                        sda_oe_o <= 1'b1;
                     end else begin
                        sda_oe_o  <= 1'b0;
                        bit_cnt_q <= '0;
                        if (state_q == ST_ADDR_ACK && shift_q[I2C_RW_BIT])
                           state_q <= ST_IGNORE;
                        else
                           state_q <= ST_DATA;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Randomized bench for i2c_slave_rx: a bit-banged master drives the bus,
// a transaction-level model queues expected bytes, a monitor scores them.
`timescale 1ns/1ps
module tb_i2c_slave_rx;

   localparam logic [6:0] ADDR = 7'h50;
   localparam int unsigned FLEN = 3;
   localparam int Q = 10;   // quarter SCL period in clk cycles
   localparam int H = 20;   // SCL high time in clk cycles

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_oe;
   logic [7:0] dat;
   logic       dat_avail;
   logic       stop;
   logic       busy;
   logic       sda_line;

   assign sda_line = sda_m & ~sda_oe;

   always #5 clk = ~clk;

   i2c_slave_rx #(.SLAVE_ADDR(ADDR), .FILTER_LEN(FLEN)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .scl_i       (scl_m),
      .sda_i       (sda_line),
      .sda_oe_o    (sda_oe),
      .dat_o       (dat),
      .dat_avail_o (dat_avail),
      .stop_o      (stop),
      .busy_o      (busy)
   );

   int total = 0;
   int bad = 0;
   logic [7:0] exp_q[$];
   int stop_exp = 0, stop_seen = 0;
   int ack_exp = 0, ack_seen = 0;

   // Transaction-level model of what the slave should do
   bit m_active = 0, m_first = 0, m_busy = 0, m_write = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_start();
      m_active = 1;
      m_first  = 1;
   endtask

   task automatic model_byte(input logic [7:0] b, output bit ack);
      ack = 0;
      if (m_active) begin
         if (m_first) begin
            m_first = 0;
            if (b[7:1] == ADDR) begin
               m_busy  = 1;
               m_write = !b[0];
               ack     = 1;
               exp_q.push_back(b);
            end else begin
               m_busy  = 0;
               m_write = 0;
            end
         end else if (m_write) begin
            ack = 1;
            exp_q.push_back(b);
         end
      end
      if (ack) ack_exp++;
   endtask

   task automatic model_stop();
      if (m_busy) stop_exp++;
      m_busy = 0; m_active = 0; m_write = 0; m_first = 0;
   endtask

   task automatic send_bit(input logic b);
      sda_m = b;  wait_cyc(Q);
      scl_m = 1;  wait_cyc(H);
      scl_m = 0;  wait_cyc(Q);
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) send_bit(b[i]);
   endtask

   task automatic i2c_start();
      sda_m = 1; wait_cyc(Q);
      scl_m = 1; wait_cyc(Q);
      sda_m = 0; wait_cyc(Q);
      scl_m = 0; wait_cyc(Q);
      model_start();
   endtask

   task automatic i2c_stop();
      sda_m = 0; wait_cyc(Q);
      scl_m = 1; wait_cyc(Q);
      sda_m = 1; wait_cyc(H);
      model_stop();
   endtask

   // Eight data bits plus the ACK clock, checking the slave's response mid-high
   task automatic send_byte(input logic [7:0] b);
      bit ack;
      model_byte(b, ack);
      send_bits(b, 8);
      sda_m = 1; wait_cyc(Q);
      scl_m = 1; wait_cyc(H / 2);
      check("ack_drive", 32'(sda_oe), 32'(ack));
      check("busy", 32'(busy), 32'(m_busy));
      wait_cyc(H / 2);
      scl_m = 0; wait_cyc(Q);
   endtask

   task automatic end_test(input string name);
      wait_cyc(20);
      check({name, "_pending"}, 32'(exp_q.size()), 0);
      check({name, "_stops"}, 32'(stop_seen), 32'(stop_exp));
      check({name, "_acks"}, 32'(ack_seen), 32'(ack_exp));
   endtask

   // Monitor: pops the scoreboard on every byte strobe, counts stops and ACKs
   initial begin
      logic [7:0] e;
      logic av_prev, oe_prev;
      av_prev = 0;
      oe_prev = 0;
      forever begin
         @(negedge clk);
         if (dat_avail) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL dat_unexpected: got 0x%02h expected no byte", dat);
            end else begin
               e = exp_q.pop_front();
               if (dat !== e) begin
                  bad++;
                  $display("FAIL dat_value: got 0x%02h expected 0x%02h", dat, e);
               end
            end
            total++;
            if (av_prev || stop) begin
               bad++;
               $display("FAIL dat_pulse: got prev=%0b stop=%0b expected 0 0", av_prev, stop);
            end
         end
         if (stop) stop_seen++;
         if (sda_oe && !oe_prev) ack_seen++;
         av_prev = dat_avail;
         oe_prev = sda_oe;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [7:0] a;
      int nd;

      // Reset state
      wait_cyc(4);
      check("rst_sda_oe", 32'(sda_oe), 0);
      check("rst_dat", 32'(dat), 0);
      check("rst_avail", 32'(dat_avail), 0);
      check("rst_stop", 32'(stop), 0);
      check("rst_busy", 32'(busy), 0);
      rst_n = 1;
      wait_cyc(20);

      // Matching write
      i2c_start();
      send_byte(8'hA0); send_byte(8'h10); send_byte(8'h3C);
      i2c_stop();
      end_test("write");

      // Address mismatch
      i2c_start();
      send_byte(8'hA2); send_byte(8'h55);
      i2c_stop();
      end_test("mismatch");

      // Read request: ACK on address, then eight released clocks
      i2c_start();
      send_byte(8'hA1);
      send_bits(8'hFF, 8);
      i2c_stop();
      end_test("read");

      // Aborted byte followed by repeated START
      i2c_start();
      send_byte(8'hA0);
      send_bits(8'h5A, 4);
      i2c_start();
      send_byte(8'hA0); send_byte(8'h77);
      i2c_stop();
      end_test("abort");

      // Short SDA glitch with SCL high must not open a transaction
      wait_cyc(5);
      sda_m = 0; wait_cyc(2);
      sda_m = 1; wait_cyc(20);
      check("glitch_busy", 32'(busy), 0);
      scl_m = 0; wait_cyc(Q);
      send_byte(8'hA0);
      i2c_stop();
      end_test("glitch");

      // Randomized transactions
      for (int t = 0; t < 12; t++) begin
         case ($urandom_range(0, 3))
            0, 3:    a = 8'hA0;
            1:       a = 8'hA1;
            default: a = 8'($urandom_range(0, 255));
         endcase
         i2c_start();
         send_byte(a);
         nd = int'($urandom_range(0, 3));
         for (int k = 0; k < nd; k++) send_byte(8'($urandom_range(0, 255)));
         if ($urandom_range(0, 3) == 0) begin
            send_bits(8'($urandom_range(0, 255)), int'($urandom_range(1, 7)));
            i2c_start();
            send_byte(8'hA0);
            send_byte(8'($urandom_range(0, 255)));
         end
         i2c_stop();
      end
      end_test("random");

      // Reset in the middle of the address ACK
      i2c_start();
      send_byte_partial_ack: begin
         bit ack;
         model_byte(8'hA0, ack);
         send_bits(8'hA0, 8);
         sda_m = 1;
         n = 0;
         while (!sda_oe && n < 100) begin
            wait_cyc(1);
            n++;
         end
         check("ack_before_reset", 32'(sda_oe), 32'(ack));
      end
      #2;
      rst_n = 0;
      #1;
      check("mid_rst_sda_oe", 32'(sda_oe), 0);
      check("mid_rst_dat", 32'(dat), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_avail", 32'(dat_avail), 0);
      check("mid_rst_stop", 32'(stop), 0);
      m_busy = 0; m_active = 0; m_write = 0; m_first = 0;
      wait_cyc(3);
      rst_n = 1;
      wait_cyc(Q);
      scl_m = 1; wait_cyc(H);
      scl_m = 0; wait_cyc(Q);
      i2c_stop();
      end_test("reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
